controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 56 +++++
 rtl/controller_decode.sv | 63 ++++++
 rtl/controller.sv | 73 +++++++
 tb/tb_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared definitions for the RV64I main controller: opcode/funct3 constants,
// ALU-control classes and the decoded control bundle.
package controller_pkg;

    localparam logic [6:0] OPC_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10
    } br_type_t;

    typedef struct packed {
        alu_op_t  alu_op;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     alu_src;
        br_type_t br_type;
        logic     illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op:     ALU_ADD,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        br_type:    BR_NONE,
        illegal:    1'b0
    };

    function automatic logic branch_taken(input br_type_t br_type, input logic zero);
        case (br_type)
            BR_EQ:   return zero;
            BR_NE:   return ~zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/controller_decode.sv
// Combinational instruction decoder: maps an RV64I word to the control bundle.
// Unrecognised encodings decode to NOP; illegal flags NOPs other than all-zero.
module controller_decode
    import controller_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       recognized;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    always_comb begin
        ctrl       = CTRL_NOP;
        recognized = 1'b0;
        case (opcode)
            OPC_R_TYPE: begin
                recognized     = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.reg_write = 1'b1;
            end
            OPC_I_ARITH: begin
                recognized     = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_LOAD: begin
                recognized      = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OPC_STORE: begin
                recognized     = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    recognized   = 1'b1;
                    ctrl.alu_op  = ALU_SUB;
                    ctrl.br_type = BR_EQ;
                end else if (funct3 == F3_BNE) begin
                    recognized   = 1'b1;
                    ctrl.alu_op  = ALU_SUB;
                    ctrl.br_type = BR_NE;
                end
            end
            default: ;
        endcase
        // An all-zero word is treated as a benign bubble, not an illegal op.
        ctrl.illegal = ~recognized & (|instruction);
    end

endmodule

// File: rtl/controller.sv
// Main controller top: decode, optional output register stage and the live
// Branch gate. Optional illegal/illegal_seen ports under CONTROLLER_ILLEGAL_EN.
module controller
    import controller_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        Zero,
    output logic [1:0]  ALUop,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic        Branch
`ifdef CONTROLLER_ILLEGAL_EN
    ,
    output logic        illegal,
    output logic        illegal_seen
`endif
);

    ctrl_t dec;
    ctrl_t ctrl;

    controller_decode u_decode (
        .instruction (instruction),
        .ctrl        (dec)
    );

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ctrl <= CTRL_NOP;
                end else begin
                    ctrl <= dec;
                end
            end
        end else begin : g_comb_out
            assign ctrl = dec;
        end
    endgenerate

    assign ALUop    = ctrl.alu_op;
    assign RegWrite = ctrl.reg_write;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign MemToReg = ctrl.mem_to_reg;
    assign ALUSrc   = ctrl.alu_src;

    // Zero arrives from the ALU in the same cycle, so Branch must stay unregistered.
    assign Branch = branch_taken(ctrl.br_type, Zero);

`ifdef CONTROLLER_ILLEGAL_EN
    assign illegal = ctrl.illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_seen <= 1'b0;
        end else if (dec.illegal) begin
            illegal_seen <= 1'b1;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = ctrl.illegal;
`endif

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed scenarios then randomized
// instructions against a behavioural decode model.
module tb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        Zero;
    logic [1:0]  ALUop;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        ALUSrc;
    logic        Branch;
`ifdef CONTROLLER_ILLEGAL_EN
    logic        illegal;
    logic        illegal_seen;
    bit          seen_exp;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] held;
    bit          held_valid;

    controller #(.REG_OUT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .Zero         (Zero),
        .ALUop        (ALUop),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemToReg     (MemToReg),
        .ALUSrc       (ALUSrc),
        .Branch       (Branch)
`ifdef CONTROLLER_ILLEGAL_EN
        ,
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] aop;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       asrc;
        int         bt;    // 0 none, 1 beq, 2 bne
        logic       ill;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        op     = ins[6:0];
        f3     = ins[14:12];
        e.aop  = 2'b00;
        e.rw   = 1'b0;
        e.mr   = 1'b0;
        e.mw   = 1'b0;
        e.m2r  = 1'b0;
        e.asrc = 1'b0;
        e.bt   = 0;
        e.ill  = 1'b0;
        if (op == 7'h33) begin
            e.aop = 2'b10; e.rw = 1'b1;
        end else if (op == 7'h13) begin
            e.aop = 2'b10; e.rw = 1'b1; e.asrc = 1'b1;
        end else if (op == 7'h03) begin
            e.rw = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.asrc = 1'b1;
        end else if (op == 7'h23) begin
            e.mw = 1'b1; e.asrc = 1'b1;
        end else if (op == 7'h63 && f3 < 3'd2) begin
            e.aop = 2'b01;
            e.bt  = (f3 == 3'd0) ? 1 : 2;
        end else begin
            e.ill = (ins != 32'h0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string ctx);
        exp_t e;
        logic br;
        e = model(32'h0);
        if (held_valid) e = model(held);
        br = (e.bt == 1) ? Zero : (e.bt == 2) ? ~Zero : 1'b0;
        chk({ctx, " ALUop"},    {30'b0, ALUop}, {30'b0, e.aop});
        chk({ctx, " RegWrite"}, {31'b0, RegWrite}, {31'b0, e.rw});
        chk({ctx, " MemRead"},  {31'b0, MemRead},  {31'b0, e.mr});
        chk({ctx, " MemWrite"}, {31'b0, MemWrite}, {31'b0, e.mw});
        chk({ctx, " MemToReg"}, {31'b0, MemToReg}, {31'b0, e.m2r});
        chk({ctx, " ALUSrc"},   {31'b0, ALUSrc},   {31'b0, e.asrc});
        chk({ctx, " Branch"},   {31'b0, Branch},   {31'b0, br});
        chk({ctx, " mem_excl"}, {31'b0, MemRead & MemWrite}, 32'h0);
`ifdef CONTROLLER_ILLEGAL_EN
        chk({ctx, " illegal"},      {31'b0, illegal},      {31'b0, held_valid ? e.ill : 1'b0});
        chk({ctx, " illegal_seen"}, {31'b0, illegal_seen}, {31'b0, seen_exp});
`endif
    endtask

    task automatic latch(input logic [31:0] ins);
`ifdef CONTROLLER_ILLEGAL_EN
        exp_t e;
        e = model(ins);
        if (e.ill) seen_exp = 1'b1;
`endif
        held       = ins;
        held_valid = 1'b1;
    endtask

    task automatic assert_reset();
        reset      = 1'b0;
        held_valid = 1'b0;
`ifdef CONTROLLER_ILLEGAL_EN
        seen_exp   = 1'b0;
`endif
    endtask

    task automatic step(input logic [31:0] ins, input string ctx);
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        latch(ins);
        #1;
        check_outputs(ctx);
    endtask

    initial begin
        Zero        = 1'b0;
        instruction = 32'h003100B3;
        held        = 32'h0;
        assert_reset();
        #1;
        check_outputs("rst_before_edge");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst_after_edges");

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        latch(instruction);
        #1;
        check_outputs("release_add");
        chk("release_regwrite", {31'b0, RegWrite}, 32'h1);
        chk("release_aluop", {30'b0, ALUop}, 32'h2);

        step(32'h0000B103, "ld");
        step(32'h0020B423, "sd");

        step(32'h00208463, "beq");
        Zero = 1'b1; #1; check_outputs("beq_z1");
        Zero = 1'b0; #1; check_outputs("beq_z0");

        step(32'h00209463, "bne");
        Zero = 1'b0; #1; check_outputs("bne_z0");
        Zero = 1'b1; #1; check_outputs("bne_z1");

        step(32'h0020A463, "branch_f3_2");
        step(32'h00000000, "all_zero");
        step(32'hFFFFFFFF, "all_ones");
        step(32'h003100B3, "legal_after_illegal");
        step(32'h00A00093, "addi_after_illegal");

        // Reset pulse between edges while beq is latched.
        step(32'h00208463, "beq_again");
        Zero = 1'b1; #1; check_outputs("beq_again_z1");
        #2;
        assert_reset();
        #1;
        check_outputs("mid_reset_branch_drop");
        #1;
        reset = 1'b1;
        @(posedge clk);
        latch(instruction);
        #1;
        check_outputs("resume_after_pulse");

        // Pending decode discarded when reset lands before the edge.
        @(negedge clk);
        instruction = 32'h0000B103;
        #2;
        assert_reset();
        #1;
        check_outputs("pending_discard");
        @(posedge clk);
        #1;
        check_outputs("pending_discard_edge");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        latch(instruction);
        #1;
        check_outputs("resume_ld");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            int          pick;
            ins  = $urandom;
            pick = $urandom_range(0, 7);
            case (pick)
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4, 5: ins[6:0] = 7'h63;
                6: if (ins[0]) ins = 32'h0;
                default: ;
            endcase
            Zero = 1'($urandom_range(0, 1));
            step(ins, "rand");
            Zero = ~Zero;
            #1;
            check_outputs("rand_zflip");
            if (i == 150) begin
                @(negedge clk);
                assert_reset();
                #1;
                check_outputs("rand_reset");
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
